// File: rtl/console_pkg.sv
// Shared types and constants for the text console writer.
package console_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PUT,
    SCR_RD,
    SCR_WR,
    CLR_ROW,
    CLR
  } state_e;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_FF = 8'h0C;

  localparam int         COLS_DEF = 40;
  localparam int         ROWS_DEF = 25;
  localparam logic [7:0] FILL_DEF = 8'h20;

endpackage

// File: rtl/console_addr.sv
// Cursor (x,y) to linear character-memory address.
module console_addr #(
  parameter int COLS = 40
) (
  input  logic [5:0] x,
  input  logic [4:0] y,
  output logic [9:0] addr
);

  generate
    if (COLS == 40) begin : g_shift
      // y*40 = y*32 + y*8
      assign addr = {y, 5'b0} + {2'b0, y, 3'b0} + {4'b0, x};
    end else begin : g_mul
      assign addr = 10'(int'(y) * COLS + int'(x));
    end
  endgenerate

endmodule

// File: rtl/text_console_writer.sv
// Byte-stream console writer: cursor tracking, wrap, newline and scroll
// into the character memory through its write/read port.
module text_console_writer
  import console_pkg::*;
#(
  parameter int         COLS = COLS_DEF,
  parameter int         ROWS = ROWS_DEF,
  parameter logic [7:0] FILL = FILL_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [9:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata,
  output logic [5:0] cursor_x,
  output logic [4:0] cursor_y,
  output logic       busy
);

  localparam logic [10:0] CELLS_I    = 11'(COLS * ROWS);
  localparam logic [10:0] COLS_I     = 11'(COLS);
  localparam logic [10:0] LAST_ROW_I = 11'(COLS * (ROWS - 1));
  localparam logic [5:0]  X_MAX      = 6'(COLS - 1);
  localparam logic [4:0]  Y_MAX      = 5'(ROWS - 1);

  state_e      state_q, state_d;
  logic [5:0]  x_q, x_d;
  logic [4:0]  y_q, y_d;
  logic [10:0] idx_q, idx_d;
  logic        ph_q, ph_d;
  logic        bs_q, bs_d;
  logic [9:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        rdy_q, rdy_d;
  logic        busy_q, busy_d;

  logic        accept;
  logic        nl;
  logic [5:0]  put_x;
  logic [9:0]  put_addr;

  assign accept = in_valid && rdy_q;
  assign put_x  = (in_data == CH_BS) ? x_q - 6'd1 : x_q;

  console_addr #(.COLS(COLS)) u_addr (
    .x    (put_x),
    .y    (y_q),
    .addr (put_addr)
  );

  // Outputs are registered for the state being entered, so mem_* always
  // describe the action of the current state. Scroll runs read,read,write,write
  // so each write takes mem_rdata from the read issued two cycles earlier;
  // COLS*(ROWS-1) must therefore be even.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    idx_d   = idx_q;
    ph_d    = ph_q;
    bs_d    = bs_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    nl      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_data == CH_LF) begin
            x_d = '0;
            nl  = 1'b1;
          end else if (in_data == CH_CR) begin
            x_d = '0;
          end else if (in_data == CH_BS) begin
            if (x_q != 6'd0) begin
              x_d     = put_x;
              bs_d    = 1'b1;
              state_d = PUT;
              we_d    = 1'b1;
              addr_d  = put_addr;
              wdata_d = FILL;
            end
          end else if (in_data == CH_FF) begin
            x_d     = '0;
            y_d     = '0;
            state_d = CLR;
            we_d    = 1'b1;
            addr_d  = '0;
            wdata_d = FILL;
            idx_d   = 11'd1;
          end else if (in_data >= 8'h20) begin
            bs_d    = 1'b0;
            state_d = PUT;
            we_d    = 1'b1;
            addr_d  = put_addr;
            wdata_d = in_data;
          end
        end
      end

      PUT: begin
        state_d = IDLE;
        if (!bs_q) begin
          if (x_q < X_MAX) begin
            x_d = x_q + 6'd1;
          end else begin
            x_d = '0;
            nl  = 1'b1;
          end
        end
      end

      SCR_RD: begin
        if (!ph_q) begin
          addr_d = 10'(idx_q);
          idx_d  = idx_q + 11'd1;
          ph_d   = 1'b1;
        end else begin
          state_d = SCR_WR;
          ph_d    = 1'b0;
          we_d    = 1'b1;
          addr_d  = 10'(idx_q - COLS_I - 11'd2);
          wdata_d = mem_rdata;
        end
      end

      SCR_WR: begin
        if (!ph_q) begin
          ph_d    = 1'b1;
          we_d    = 1'b1;
          addr_d  = 10'(idx_q - COLS_I - 11'd1);
          wdata_d = mem_rdata;
        end else if (idx_q == CELLS_I) begin
          state_d = CLR_ROW;
          ph_d    = 1'b0;
          we_d    = 1'b1;
          addr_d  = 10'(LAST_ROW_I);
          wdata_d = FILL;
          idx_d   = LAST_ROW_I + 11'd1;
        end else begin
          state_d = SCR_RD;
          ph_d    = 1'b0;
          addr_d  = 10'(idx_q);
          idx_d   = idx_q + 11'd1;
        end
      end

      CLR_ROW, CLR: begin
        if (idx_q == CELLS_I) begin
          state_d = IDLE;
        end else begin
          we_d    = 1'b1;
          addr_d  = 10'(idx_q);
          wdata_d = FILL;
          idx_d   = idx_q + 11'd1;
        end
      end

      default: state_d = CLR;
    endcase

    if (nl) begin
      if (y_q < Y_MAX) begin
        y_d     = y_q + 5'd1;
        state_d = IDLE;
      end else begin
        state_d = SCR_RD;
        ph_d    = 1'b0;
        we_d    = 1'b0;
        addr_d  = 10'(COLS_I);
        idx_d   = COLS_I + 11'd1;
      end
    end

    rdy_d  = (state_d == IDLE) && !accept;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLR;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      ph_q    <= 1'b0;
      bs_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= FILL;
      we_q    <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      ph_q    <= ph_d;
      bs_q    <= bs_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign cursor_x  = x_q;
  assign cursor_y  = y_q;
  assign busy      = busy_q;

endmodule
